mem_arbiter: RTL
================

# mem_arbiter

Byte-serial memory arbiter between the instruction-fetch stage and the MEM stage, driving the CPU's single 8-bit RAM/IO bus. It grants one 1/2/4-byte transaction at a time and sequences its bytes over `mem_a`/`mem_dout`/`mem_din`. It assembles little-endian read words, holds off IO writes while the UART is full, and aborts fetches on a branch flush. It sits between `ifetch`/`mem` and the top-level memory pins.

## Interface
Parameters:
- `ADDR_W`, 32, address width (`AddrLen`).
- `DATA_W`, 32, word width (`RegLen`/`InstLen`).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `rdy`  in  1  global ready; low freezes all state.
- `if_request`  in  1  fetch request, held until `if_enable` or dropped on flush.
- `if_addr`  in  32  fetch address.
- `if_inst`  out  32  assembled instruction, valid while `if_enable`.
- `if_enable`  out  1  one-cycle fetch-done pulse.
- `flush`  in  1  branch taken (`jump_or_not`): cancel or abort fetch.
- `d_load`, `d_store`  in  1  data request, held until `d_enable`; never both high.
- `d_addr`  in  32  data address.
- `d_nbytes`  in  3  byte count: 1, 2 or 4.
- `d_wdata`  in  32  store data, low bytes first.
- `d_rdata`  out  32  load data, zero-extended, valid while `d_enable`.
- `d_enable`  out  1  one-cycle data-done pulse.
- `mem_din`  in  8  RAM read byte, for the address of the previous active cycle.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART tx buffer full.

## Operation
- States: `IDLE`, `RD`, `WR`, `IO_GAP`.
- Byte counter: `cnt[2:0]`.
- Read capture flag: `cap`.
- **IDLE grant:**
  - Data beats fetch.
  - A data store to IO (`d_addr[17:16]==2'b11`) is not granted while `io_buffer_full`=1. Fetch may be granted instead that cycle.
  - Fetch is not granted in a cycle with `flush`=1.
- **Grant:** latch addr, `nbytes` (4 for fetch), `wdata` and requester. Go to `RD` or `WR`.
- **RD:**
  - Drive `mem_a`=base+`cnt` for `cnt`=0..N-1, with `mem_wr`=0.
  - `mem_din` is captured into byte lane `cnt-1` one cycle after each issue.
  - After the last capture, raise the done pulse of the owner and return to `IDLE`.
- **WR:**
  - Drive `mem_a`=base+`cnt`, `mem_dout`=`wdata[8cnt+7:8cnt]` and `mem_wr`=1 for N cycles.
  - Then pulse `d_enable`.
  - An IO-address write then enters `IO_GAP` for one cycle, because `io_buffer_full` lags by one cycle. Any other write goes to `IDLE`.
- **Flush:** during a fetch-owned `RD`, `flush`=1 sends the arbiter to `IDLE` next cycle with no `if_enable`, including in the final capture cycle. Data transactions ignore `flush`.
- **Unused lanes:** upper lanes of `d_rdata` are 0 for 1- and 2-byte loads.
- **Address arithmetic:** 32-bit, wraps mod 2^32. No alignment check.

## Timing
- **Outputs are registered.** Reset values: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `if_enable`=0, `d_enable`=0, `if_inst`=0, `d_rdata`=0, state `IDLE`.
- **Latency** (request seen in IDLE cycle 0):
  - Read of N bytes: `mem_a` issues in cycles 1..N, done pulse in cycle N+2. A fetch pulses `if_enable` in cycle 6.
  - Write of N bytes: `mem_wr` high in cycles 1..N, `d_enable` in cycle N+1.
- **Back-to-back:** a new grant is possible in the done-pulse cycle, because state is already `IDLE`.
- **`rdy`=0:**
  - State, counter, captured bytes and outputs hold.
  - `mem_wr` is forced 0 so no byte is written twice. The held `mem_a` keeps `mem_din` valid for the capture on resume.
  - Done pulses extend until `rdy` returns.
- **`rst` mid-transaction:** abandon immediately and apply the reset values. No done pulse.
- **Simultaneous fetch and data requests in IDLE:** data wins. The fetch waits, holding its request.

## Structure
- Shared package / `config.v` holds: state encodings, `IO_PREFIX`=2'b11, the `ADDR_W`/`DATA_W` aliases of `AddrLen`/`InstLen`/`RegLen`, and the `NB_BYTE/NB_HALF/NB_WORD` codes.
- One sub-module, `byte_assembler`: it owns `cnt`, the issue address, the capture lane decode and the 32-bit shift/assemble register. `mem_arbiter` keeps the grant FSM, IO gating, flush and done logic.

## Test plan
- **Fetch:** `if_addr`=0x100, RAM bytes 0x13,0x05,0x10,0x00 → `mem_a` 0x100..0x103 in cycles 1..4; `if_enable` in cycle 6 with `if_inst`=0x00100513.
- **Contention:** fetch 0x200 and 2-byte load 0x400 asserted together → load served first, `d_rdata`=0x0000BBAA in cycle 4. Fetch `mem_a`=0x200 then starts in cycle 5.
- **IO store:** SB to 0x30000, data 0x41, `io_buffer_full`=1 for 3 cycles → no `mem_wr` until full drops. Then one write cycle, `d_enable`, one `IO_GAP` cycle before the next grant.
- **Flush:** `flush` in cycle 3 of a fetch → state `IDLE` in cycle 4, no `if_enable`. A new fetch to the target is granted in cycle 4.
- **Pause:** `rdy`=0 for cycles 2–4 during a SW to 0x80 of 0xDEADBEEF → RAM bytes 0xEF,0xBE,0xAD,0xDE each written exactly once; `d_enable` delayed by 3 cycles.
- **Reset:** `rst` in cycle 2 of a load → all outputs 0 next cycle, no `d_enable`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial memory arbiter: state encodings,
// width aliases, IO address prefix and transaction size codes.
package mem_arbiter_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam int RegLen  = 32;

    localparam logic [1:0] IO_PREFIX = 2'b11;

    localparam logic [2:0] NB_BYTE = 3'd1;
    localparam logic [2:0] NB_HALF = 3'd2;
    localparam logic [2:0] NB_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_WR     = 2'd2,
        ST_IO_GAP = 2'd3
    } arb_state_t;

    function automatic logic is_io(input logic [AddrLen-1:0] addr);
        return addr[17:16] == IO_PREFIX;
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Byte sequencer: owns the beat counter, the issued byte address and the
// little-endian assembly of read bytes returned one cycle after each issue.
module byte_assembler
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = RegLen
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [2:0]        i_nbytes,
    input  logic              i_step,
    input  logic              i_read,
    input  logic [7:0]        i_mem_din,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_issue,
    output logic              o_last_cap,
    output logic [DATA_W-1:0] o_merged
);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_nb;
    logic [2:0]        r_cnt;
    logic              r_cap;
    logic [DATA_W-1:0] r_word;

    logic [2:0]        w_next_cnt;
    logic [1:0]        w_lane;
    logic [DATA_W-1:0] w_merged;

    assign w_next_cnt   = r_cnt + 3'd1;
    // r_cnt counts issued beats, so the byte arriving now belongs to lane cnt-1
    assign w_lane       = r_cnt[1:0] - 2'd1;
    assign o_last_issue = (w_next_cnt == r_nb);
    assign o_last_cap   = r_cap && (r_cnt == r_nb);
    assign o_addr       = r_addr;
    assign o_merged     = w_merged;

    always_comb begin
        w_merged = r_word;
        if (r_cap) begin
            w_merged[{w_lane, 3'b000} +: 8] = i_mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_addr <= '0;
            r_nb   <= '0;
            r_cnt  <= '0;
            r_cap  <= 1'b0;
            r_word <= '0;
        end else if (rdy) begin
            if (i_start) begin
                r_base <= i_base;
                r_addr <= i_base;
                r_nb   <= i_nbytes;
                r_cnt  <= '0;
                r_cap  <= 1'b0;
                r_word <= '0;
            end else if (i_step) begin
                r_cap <= i_read;
                if (r_cnt != r_nb) begin
                    r_cnt <= w_next_cnt;
                end
                if (w_next_cnt < r_nb) begin
                    r_addr <= r_base + ADDR_W'(w_next_cnt);
                end
                if (r_cap) begin
                    r_word <= w_merged;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and the MEM stage for the single 8-bit
// RAM/IO bus: grant FSM, IO-full gating, fetch flush and done pulses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = RegLen
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_request,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_enable,
    input  logic              flush,
    input  logic              d_load,
    input  logic              d_store,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_nbytes,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_enable,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_owner_if;
    logic              r_io;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;
    logic              r_if_enable;
    logic              r_d_enable;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_abort;
    logic              w_step;
    logic              w_fin_rd;
    logic              w_done_if;
    logic              w_done_d;
    logic              w_last_issue;
    logic              w_last_cap;
    logic [DATA_W-1:0] w_merged;
    logic [ADDR_W-1:0] w_addr;

    // Requests stay high through their own done pulse, so mask them there
    assign w_grant_d  = (r_state == ST_IDLE) && (d_load || d_store) && !r_d_enable
                        && !(d_store && is_io(d_addr) && io_buffer_full);
    assign w_grant_if = (r_state == ST_IDLE) && !w_grant_d && if_request
                        && !r_if_enable && !flush;
    assign w_abort    = (r_state == ST_RD) && r_owner_if && flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = d_store ? ST_WR : ST_RD;
                end else if (w_grant_if) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                if (w_abort || w_last_cap) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (w_last_issue) begin
                    w_state_nxt = r_io ? ST_IO_GAP : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_step    = ((r_state == ST_RD) && !w_abort) || (r_state == ST_WR);
        w_fin_rd  = (r_state == ST_RD) && w_last_cap && !w_abort;
        w_done_if = w_fin_rd && r_owner_if;
        w_done_d  = (w_fin_rd && !r_owner_if) || ((r_state == ST_WR) && w_last_issue);
    end

    byte_assembler #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .i_start     (w_grant_d || w_grant_if),
        .i_base      (w_grant_d ? d_addr : if_addr),
        .i_nbytes    (w_grant_d ? d_nbytes : NB_WORD),
        .i_step      (w_step),
        .i_read      (r_state == ST_RD),
        .i_mem_din   (mem_din),
        .o_addr      (w_addr),
        .o_last_issue(w_last_issue),
        .o_last_cap  (w_last_cap),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_if  <= 1'b0;
            r_io        <= 1'b0;
            r_wdata     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_if_enable <= 1'b0;
            r_d_enable  <= 1'b0;
            r_if_inst   <= '0;
            r_d_rdata   <= '0;
        end else if (rdy) begin
            r_if_enable <= w_done_if;
            r_d_enable  <= w_done_d;
            if (w_done_if) begin
                r_if_inst <= w_merged;
            end
            if (w_fin_rd && !r_owner_if) begin
                r_d_rdata <= w_merged;
            end
            if (w_grant_d || w_grant_if) begin
                r_owner_if <= w_grant_if;
                r_io       <= w_grant_d && d_store && is_io(d_addr);
                r_mem_wr   <= w_grant_d && d_store;
                if (w_grant_d && d_store) begin
                    r_mem_dout <= d_wdata[7:0];
                    r_wdata    <= d_wdata >> 8;
                end
            end else if (r_state == ST_WR) begin
                if (w_last_issue) begin
                    r_mem_wr <= 1'b0;
                end else begin
                    r_mem_dout <= r_wdata[7:0];
                    r_wdata    <= r_wdata >> 8;
                end
            end
        end
    end

    // A paused bus must never repeat a write strobe
    assign mem_wr    = r_mem_wr && rdy;
    assign mem_a     = w_addr;
    assign mem_dout  = r_mem_dout;
    assign if_enable = r_if_enable;
    assign d_enable  = r_d_enable;
    assign if_inst   = r_if_inst;
    assign d_rdata   = r_d_rdata;

endmodule
